// File: rtl/alu_pkg.sv
// Shared constants and payload type for the RV32I ALU issue stage.
// Holds the ALU op encoding, opcode/funct7 values and the funct3-to-op mapping.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_AND  = 4'b1001,
    ALU_OR   = 4'b1010,
    ALU_XOR  = 4'b1011,
    ALU_SLTU = 4'b1100,
    ALU_SLT  = 4'b1101
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [31:0] a_data;
    logic [31:0] b_data;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } issue_payload_t;

  // alt selects sub/sra; callers only pass alt where that variant exists.
  function automatic alu_op_e funct3_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode: instruction word, pc and register data in,
// ALU op, selected operands, rd and write-back/illegal flags out.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]    instr,
  input  logic [31:0]    pc,
  input  logic [31:0]    rs1_data,
  input  logic [31:0]    rs2_data,
  output issue_payload_t payload
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic        is_shift;
  logic        alt;
  logic        legal;
  logic        writes;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u    = {instr[31:12], 12'b0};
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign alt      = (funct7 == F7_ALT);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    payload = '0;
    legal   = 1'b1;
    writes  = 1'b1;
    case (opcode)
      OPC_OP: begin
        payload.alu_op = funct3_op(funct3, alt);
        payload.a_data = rs1_data;
        payload.b_data = rs2_data;
        legal = (funct7 == F7_BASE) || (alt && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OP_IMM: begin
        // Only shifts reuse instr[31:25]; for the rest those bits are immediate.
        payload.alu_op = funct3_op(funct3, is_shift && alt);
        payload.a_data = rs1_data;
        payload.b_data = is_shift ? {27'b0, instr[24:20]} : imm_i;
        legal = !is_shift || (funct7 == F7_BASE) || (alt && funct3 == 3'b101);
      end
      OPC_LUI:   payload.b_data = imm_u;
      OPC_AUIPC: begin
        payload.a_data = pc;
        payload.b_data = imm_u;
      end
      OPC_LOAD: begin
        payload.a_data = rs1_data;
        payload.b_data = imm_i;
      end
      OPC_STORE: begin
        payload.a_data = rs1_data;
        payload.b_data = imm_s;
        writes = 1'b0;
      end
      OPC_BRANCH: begin
        payload.a_data = rs1_data;
        payload.b_data = rs2_data;
        writes = 1'b0;
        case (funct3[2:1])
          2'b00:   payload.alu_op = ALU_SUB;
          2'b10:   payload.alu_op = ALU_SLT;
          2'b11:   payload.alu_op = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        payload.a_data = pc;
        payload.b_data = 32'd4;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      payload.alu_op = ALU_ADD;
      payload.a_data = '0;
      payload.b_data = '0;
    end
    payload.store_data = rs2_data;
    payload.rd         = instr[11:7];
    payload.reg_write  = legal && writes && (instr[11:7] != 5'd0);
    payload.illegal    = !legal;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-entry stage: decodes an RV32I instruction and presents the ALU
// payload from a registered valid/ready buffer (main register plus optional skid).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter bit SKID_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic [31:0] a_data,
  output logic [31:0] b_data,
  output logic [31:0] store_data,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal
);

  issue_payload_t dec_payload;
  issue_payload_t main_q;
  issue_payload_t skid_q;
  logic           main_valid;
  logic           skid_valid;
  logic           accept;
  logic           drain;
  logic           main_free;

  alu_decode u_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .payload  (dec_payload)
  );

  // With the skid buffer, in_ready is a flop value and never sees out_ready.
  assign in_ready  = !reset && (SKID_EN ? !skid_valid : (!main_valid || out_ready));
  assign accept    = in_valid && in_ready && !flush;
  assign drain     = main_valid && out_ready;
  assign main_free = !main_valid || drain;

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      // NOTE: payload registers are reset too, since downstream must see all-zero outputs in reset.
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_q <= dec_payload;
      end
    end else if (accept) begin
      skid_q     <= dec_payload;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid  = main_valid;
  assign alu_op     = main_q.alu_op;
  assign a_data     = main_q.a_data;
  assign b_data     = main_q.b_data;
  assign store_data = main_q.store_data;
  assign rd         = main_q.rd;
  assign reg_write  = main_q.reg_write;
  assign illegal    = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: instructions are built from mnemonic
// tables with known results, and a queue models the two-entry buffer.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } pl_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, a_data, b_data, store_data;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        reg_write, illegal;

  int   tests_run    = 0;
  int   tests_failed = 0;
  pl_t  model_q[$];
  logic acc_s, drn_s;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .a_data(a_data), .b_data(b_data), .store_data(store_data),
    .rd(rd), .reg_write(reg_write), .illegal(illegal)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic pl_t dut_pl();
    pl_t p;
    p = {alu_op, a_data, b_data, store_data, rd, reg_write, illegal};
    return p;
  endfunction

  // One clock of stimulus starting just after a falling edge; compares the
  // visible state against the queue model, then advances the model.
  task automatic drive_cycle(input logic iv, input logic ordy, input logic fl,
                             input logic [31:0] ins, input logic [31:0] p,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input pl_t exp, output logic acc, output logic drn);
    logic exp_ov, exp_ir;
    in_valid = iv; out_ready = ordy; flush = fl;
    instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
    #1;
    exp_ov = (model_q.size() > 0);
    exp_ir = (model_q.size() < 2);
    tests_run++;
    if (out_valid !== exp_ov || in_ready !== exp_ir) begin
      tests_failed++;
      $display("FAIL handshake: out_valid=%b in_ready=%b, expected %b %b (depth %0d)",
               out_valid, in_ready, exp_ov, exp_ir, model_q.size());
    end
    if (exp_ov) begin
      tests_run++;
      if (dut_pl() !== model_q[0]) begin
        tests_failed++;
        $display("FAIL payload: got %h expected %h", dut_pl(), model_q[0]);
      end
    end
    acc = iv && exp_ir && !fl;
    drn = exp_ov && ordy;
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (drn) model_q.delete(0);
      if (acc) model_q.push_back(exp);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return 32'(int'($signed(v)));
  endfunction

  // Builds a random instruction of the given class with its expected payload.
  task automatic gen(input int kind, output logic [31:0] ins, output logic [31:0] p,
                     output logic [31:0] r1, output logic [31:0] r2, output pl_t e);
    logic [4:0]  rdf, rs1f, rs2f;
    logic [11:0] imm12;
    logic [19:0] imm20;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        wr;
    int          j;
    rdf = 5'($urandom); rs1f = 5'($urandom); rs2f = 5'($urandom);
    imm12 = 12'($urandom); imm20 = 20'($urandom);
    p = $urandom & 32'hFFFF_FFFC; r1 = $urandom; r2 = $urandom;
    e = '0; e.sd = r2; wr = 1'b1; f7 = 7'h00; f3 = 3'b000; ins = '0;
    case (kind)
      0: begin
        j = int'($urandom_range(0, 9));
        case (j)
          0: begin f3 = 3'd0; e.op = 4'b0000; end
          1: begin f3 = 3'd0; f7 = 7'h20; e.op = 4'b0001; end
          2: begin f3 = 3'd1; e.op = 4'b0100; end
          3: begin f3 = 3'd2; e.op = 4'b1101; end
          4: begin f3 = 3'd3; e.op = 4'b1100; end
          5: begin f3 = 3'd4; e.op = 4'b1011; end
          6: begin f3 = 3'd5; e.op = 4'b0110; end
          7: begin f3 = 3'd5; f7 = 7'h20; e.op = 4'b0111; end
          8: begin f3 = 3'd6; e.op = 4'b1010; end
          default: begin f3 = 3'd7; e.op = 4'b1001; end
        endcase
        ins = {f7, rs2f, rs1f, f3, rdf, 7'b0110011};
        e.a = r1; e.b = r2;
      end
      1: begin
        j = int'($urandom_range(0, 5));
        case (j)
          0: begin f3 = 3'd0; e.op = 4'b0000; end
          1: begin f3 = 3'd2; e.op = 4'b1101; end
          2: begin f3 = 3'd3; e.op = 4'b1100; end
          3: begin f3 = 3'd4; e.op = 4'b1011; end
          4: begin f3 = 3'd6; e.op = 4'b1010; end
          default: begin f3 = 3'd7; e.op = 4'b1001; end
        endcase
        ins = {imm12, rs1f, f3, rdf, 7'b0010011};
        e.a = r1; e.b = sext12(imm12);
      end
      2: begin
        j = int'($urandom_range(0, 2));
        case (j)
          0: begin f3 = 3'd1; e.op = 4'b0100; end
          1: begin f3 = 3'd5; e.op = 4'b0110; end
          default: begin f3 = 3'd5; f7 = 7'h20; e.op = 4'b0111; end
        endcase
        ins = {f7, rs2f, rs1f, f3, rdf, 7'b0010011};
        e.a = r1; e.b = 32'(rs2f);
      end
      3: begin ins = {imm20, rdf, 7'b0110111}; e.a = 32'd0; e.b = {imm20, 12'h000}; end
      4: begin ins = {imm20, rdf, 7'b0010111}; e.a = p; e.b = {imm20, 12'h000}; end
      5: begin ins = {imm12, rs1f, 3'b010, rdf, 7'b0000011}; e.a = r1; e.b = sext12(imm12); end
      6: begin
        ins = {imm12[11:5], rs2f, rs1f, 3'b010, imm12[4:0], 7'b0100011};
        e.a = r1; e.b = sext12(imm12); wr = 1'b0;
      end
      7: begin
        j = int'($urandom_range(0, 5));
        case (j)
          0: begin f3 = 3'd0; e.op = 4'b0001; end
          1: begin f3 = 3'd1; e.op = 4'b0001; end
          2: begin f3 = 3'd4; e.op = 4'b1101; end
          3: begin f3 = 3'd5; e.op = 4'b1101; end
          4: begin f3 = 3'd6; e.op = 4'b1100; end
          default: begin f3 = 3'd7; e.op = 4'b1100; end
        endcase
        ins = {imm12[11:5], rs2f, rs1f, f3, imm12[4:0], 7'b1100011};
        e.a = r1; e.b = r2; wr = 1'b0;
      end
      8: begin ins = {imm20, rdf, 7'b1101111}; e.a = p; e.b = 32'd4; end
      9: begin ins = {imm12, rs1f, 3'b000, rdf, 7'b1100111}; e.a = p; e.b = 32'd4; end
      default: begin
        j = int'($urandom_range(0, 3));
        case (j)
          0: ins = {imm20, rdf, 7'b1111111};
          1: ins = {7'b0000001, rs2f, rs1f, 3'($urandom), rdf, 7'b0110011};
          2: ins = {imm12[11:5], rs2f, rs1f, 2'b01, 1'($urandom), imm12[4:0], 7'b1100011};
          default: ins = {7'h20, rs2f, rs1f, 3'b001, rdf, 7'b0010011};
        endcase
        e.op = 4'b0000; e.a = 32'd0; e.b = 32'd0; wr = 1'b0; e.ill = 1'b1;
      end
    endcase
    e.rd = ins[11:7];
    e.rw = wr && (ins[11:7] != 5'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    instr = 32'h002081B3; pc = '0; rs1_data = 32'd5; rs2_data = 32'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
    end
    tests_run++;
    if (dut_pl() !== '0) begin
      tests_failed++;
      $display("FAIL reset_payload: got %h expected 0", dut_pl());
    end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    model_q.delete();
  endtask

  task automatic test_decode();
    logic [31:0] ti[4], tp[4], t1[4], t2[4];
    pl_t         te[4];
    ti[0] = 32'h002081B3; tp[0] = 32'h0;   t1[0] = 32'd5;        t2[0] = 32'd7;
    te[0] = '{4'b0000, 32'd5, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0};
    ti[1] = 32'h40435293; tp[1] = 32'h0;   t1[1] = 32'h8000_0000; t2[1] = 32'h11;
    te[1] = '{4'b0111, 32'h8000_0000, 32'd4, 32'h11, 5'd5, 1'b1, 1'b0};
    ti[2] = 32'hFFF00093; tp[2] = 32'h0;   t1[2] = 32'h0;        t2[2] = 32'h22;
    te[2] = '{4'b0000, 32'h0, 32'hFFFF_FFFF, 32'h22, 5'd1, 1'b1, 1'b0};
    ti[3] = 32'h12345097; tp[3] = 32'h100; t1[3] = 32'h55;       t2[3] = 32'h66;
    te[3] = '{4'b0000, 32'h100, 32'h1234_5000, 32'h66, 5'd1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, ti[k], tp[k], t1[k], t2[k], te[k], acc_s, drn_s);
      drive_cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0, acc_s, drn_s);
    end
  endtask

  task automatic test_illegal_x0();
    logic [31:0] ti[3], t1[3], t2[3];
    pl_t         te[3];
    ti[0] = 32'hFFFFFFFF; t1[0] = 32'h44; t2[0] = 32'h33;
    te[0] = '{4'b0000, 32'h0, 32'h0, 32'h33, 5'h1F, 1'b0, 1'b1};
    ti[1] = 32'h00208033; t1[1] = 32'd9;  t2[1] = 32'd4;
    te[1] = '{4'b0000, 32'd9, 32'd4, 32'd4, 5'd0, 1'b0, 1'b0};
    ti[2] = 32'h0020C063; t1[2] = 32'd1;  t2[2] = 32'd2;
    te[2] = '{4'b1101, 32'd1, 32'd2, 32'd2, 5'd0, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, ti[k], 32'h200, t1[k], t2[k], te[k], acc_s, drn_s);
      drive_cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0, acc_s, drn_s);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] bi[4], bp[4], b1[4], b2[4];
    pl_t         be[4];
    int          idx, drains, c, last_drain;
    for (int k = 0; k < 4; k++) gen(int'($urandom_range(0, 10)), bi[k], bp[k], b1[k], b2[k], be[k]);
    idx = 0; drains = 0; c = 0;
    while ((idx < 4 || model_q.size() > 0) && c < 20) begin
      if (c == 2 || c == 4) begin
        tests_run++;
        if (idx !== 2) begin
          tests_failed++;
          $display("FAIL bp_accepted_while_held: cycle %0d accepted %0d, expected 2", c, idx);
        end
      end
      drive_cycle(idx < 4, !(c >= 1 && c <= 3), 1'b0, bi[idx < 4 ? idx : 0], bp[idx < 4 ? idx : 0],
                  b1[idx < 4 ? idx : 0], b2[idx < 4 ? idx : 0], be[idx < 4 ? idx : 0], acc_s, drn_s);
      if (acc_s) idx++;
      if (drn_s) drains++;
      c++;
    end
    tests_run++;
    if (drains !== 4 || c >= 20) begin
      tests_failed++;
      $display("FAIL bp_drain: drained %0d in %0d cycles, expected 4 within budget", drains, c);
    end

    for (int k = 0; k < 4; k++) gen(int'($urandom_range(0, 10)), bi[k], bp[k], b1[k], b2[k], be[k]);
    idx = 0; drains = 0; c = 0; last_drain = -1;
    while ((idx < 4 || model_q.size() > 0) && c < 20) begin
      drive_cycle(idx < 4, 1'b1, 1'b0, bi[idx < 4 ? idx : 0], bp[idx < 4 ? idx : 0],
                  b1[idx < 4 ? idx : 0], b2[idx < 4 ? idx : 0], be[idx < 4 ? idx : 0], acc_s, drn_s);
      if (acc_s) idx++;
      if (drn_s) begin drains++; last_drain = c; end
      c++;
    end
    tests_run++;
    if (drains !== 4 || last_drain !== 4) begin
      tests_failed++;
      $display("FAIL back_to_back: drained %0d, last at cycle %0d, expected 4 and 4", drains, last_drain);
    end
  endtask

  task automatic test_flush();
    logic [31:0] gi, gp, g1, g2;
    pl_t         ge;
    for (int k = 0; k < 2; k++) begin
      gen(int'($urandom_range(0, 10)), gi, gp, g1, g2, ge);
      drive_cycle(1'b1, 1'b0, 1'b0, gi, gp, g1, g2, ge, acc_s, drn_s);
    end
    gen(1, gi, gp, g1, g2, ge);
    drive_cycle(1'b1, 1'b0, 1'b1, gi, gp, g1, g2, ge, acc_s, drn_s);
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0, acc_s, drn_s);
    gen(0, gi, gp, g1, g2, ge);
    drive_cycle(1'b1, 1'b1, 1'b0, gi, gp, g1, g2, ge, acc_s, drn_s);
    gen(3, gi, gp, g1, g2, ge);
    drive_cycle(1'b1, 1'b1, 1'b1, gi, gp, g1, g2, ge, acc_s, drn_s);
    drive_cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0, acc_s, drn_s);
  endtask

  task automatic test_random();
    logic [31:0] gi, gp, g1, g2;
    pl_t         ge;
    for (int n = 0; n < 3000; n++) begin
      gen(int'($urandom_range(0, 10)), gi, gp, g1, g2, ge);
      drive_cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 64) == 0,
                  gi, gp, g1, g2, ge, acc_s, drn_s);
    end
    for (int n = 0; n < 3; n++) drive_cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0, acc_s, drn_s);
  endtask

  task automatic test_reset_mid();
    logic [31:0] gi, gp, g1, g2;
    pl_t         ge;
    for (int k = 0; k < 2; k++) begin
      gen(int'($urandom_range(0, 9)), gi, gp, g1, g2, ge);
      drive_cycle(1'b1, 1'b0, 1'b0, gi, gp, g1, g2, ge, acc_s, drn_s);
    end
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_ready: in_ready=%b expected 0", in_ready);
    end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || dut_pl() !== '0) begin
        tests_failed++;
        $display("FAIL reset_mid_hold: out_valid=%b in_ready=%b payload=%h, expected 0 0 0",
                 out_valid, in_ready, dut_pl());
      end
    end
    reset = 1'b0; flush = 1'b0;
    model_q.delete();
    gen(4, gi, gp, g1, g2, ge);
    drive_cycle(1'b1, 1'b1, 1'b0, gi, gp, g1, g2, ge, acc_s, drn_s);
    drive_cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0, acc_s, drn_s);
    drive_cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0, acc_s, drn_s);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_illegal_x0();
    test_back_pressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
